// File: rtl/operand_issuer_pkg.sv
// Shared constants and types for the operand issuer and its operand FIFO.
package operand_issuer_pkg;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned LATENCY    = 3;
  localparam int unsigned OP_W       = 8;
  localparam int unsigned RES_W      = 16;
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W      = PTR_W + 1;

  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
    logic [OP_W-1:0] c;
  } operand_t;

  typedef enum logic [1:0] {
    IssPop,
    IssBubble,
    IssFreeze
  } issue_e;

  // What the issue stage does on the coming edge.
  function automatic issue_e issue_action(input logic hold, input logic empty);
    if (hold) begin
      return IssFreeze;
    end else if (empty) begin
      return IssBubble;
    end
    return IssPop;
  endfunction

endpackage

// File: rtl/operand_issuer_if.sv
// Bundle between the operand issuer and its producer / equation pipeline.
// ISSUE_TAG_EN adds the res_tag result tag.
interface operand_issuer_if;
  import operand_issuer_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  in_a;
  logic [OP_W-1:0]  in_b;
  logic [OP_W-1:0]  in_c;
  logic             hold;
  logic [OP_W-1:0]  A;
  logic [OP_W-1:0]  B;
  logic [OP_W-1:0]  C;
  logic             stall;
  logic [RES_W-1:0] E;
  logic             res_valid;
  logic [RES_W-1:0] res_data;
  logic [CNT_W-1:0] occupancy;
`ifdef ISSUE_TAG_EN
  logic [1:0]       res_tag;

  modport slave (
    input  in_valid, in_a, in_b, in_c, hold, E,
    output in_ready, A, B, C, stall, res_valid, res_data, occupancy, res_tag
  );
  modport master (
    output in_valid, in_a, in_b, in_c, hold, E,
    input  in_ready, A, B, C, stall, res_valid, res_data, occupancy, res_tag
  );
`else
  modport slave (
    input  in_valid, in_a, in_b, in_c, hold, E,
    output in_ready, A, B, C, stall, res_valid, res_data, occupancy
  );
  modport master (
    output in_valid, in_a, in_b, in_c, hold, E,
    input  in_ready, A, B, C, stall, res_valid, res_data, occupancy
  );
`endif

endinterface

// File: rtl/issue_fifo.sv
// Operand FIFO: no bypass, push refused when full regardless of a same-cycle pop.
module issue_fifo
  import operand_issuer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  operand_t         wdata_i,
  output operand_t         rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  operand_t         mem_q [FIFO_DEPTH];
  operand_t         mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_d, wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_d, rd_ptr_q;
  logic [CNT_W-1:0] count_d, count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);  // depth is a power of two: wraps
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/operand_issuer.sv
// Feeds queued operand triples into a freezable equation pipeline and flags its results.
// ISSUE_TAG_EN adds a 2-bit per-result tag (res_tag).
module operand_issuer
  import operand_issuer_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  operand_issuer_if.slave bus
);

  operand_t         head, in_ops, ops_d, ops_q;
  logic             full, empty, push, pop, shift;
  logic [CNT_W-1:0] count;
  issue_e           action;
  logic [LATENCY:0] vpipe_d, vpipe_q;
  logic             shifted_d, shifted_q;
  logic             stall_d, stall_q;

  assign in_ops = {bus.in_a, bus.in_b, bus.in_c};

  issue_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (in_ops),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  always_comb begin
    action    = issue_action(bus.hold, empty);
    pop       = (action == IssPop);
    shift     = (action != IssFreeze);
    push      = bus.in_valid && !full;
    ops_d     = pop ? head : ops_q;
    vpipe_d   = shift ? {vpipe_q[LATENCY-1:0], pop} : vpipe_q;
    shifted_d = shift;
    stall_d   = bus.hold;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ops_q     <= '0;
      vpipe_q   <= '0;
      shifted_q <= 1'b0;
      stall_q   <= 1'b0;
    end else begin
      ops_q     <= ops_d;
      vpipe_q   <= vpipe_d;
      shifted_q <= shifted_d;
      stall_q   <= stall_d;
    end
  end

  assign bus.in_ready  = !full;
  assign bus.occupancy = count;
  assign bus.A         = ops_q.a;
  assign bus.B         = ops_q.b;
  assign bus.C         = ops_q.c;
  assign bus.stall     = stall_q;
  // Qualifying with the last-edge shift keeps a frozen last bit from pulsing again.
  assign bus.res_valid = vpipe_q[LATENCY] && shifted_q;
  assign bus.res_data  = bus.E;

`ifdef ISSUE_TAG_EN
  logic [1:0]            tag_d, tag_q;
  logic [LATENCY:0][1:0] tag_pipe_d, tag_pipe_q;

  always_comb begin
    tag_d      = pop ? tag_q + 2'd1 : tag_q;
    tag_pipe_d = shift ? {tag_pipe_q[LATENCY-1:0], tag_q} : tag_pipe_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q      <= '0;
      tag_pipe_q <= '0;
    end else begin
      tag_q      <= tag_d;
      tag_pipe_q <= tag_pipe_d;
    end
  end

  assign bus.res_tag = tag_pipe_q[LATENCY];
`endif

endmodule
